// File: rtl/sdu_scan.sv
// sdu_scan: serial debug receive scanner returning one command char or hex word per request.
// Define SDU_SCAN_ECHO_EN to echo every received byte to the UART transmitter.
module sdu_scan #(
   parameter int MAX_DIGITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_rx,
   input  logic        type_rx,
   output logic        ack_rx,
   output logic        flag_rx,
   output logic [31:0] dout_rx,
   input  logic        vld_rx,
   input  logic [7:0]  d_rx,
   output logic        rdy_rx,
   output logic        vld_tx,
   output logic [7:0]  d_tx,
   input  logic        rdy_tx
);
`ifdef SDU_SCAN_ECHO_EN
   typedef enum logic [2:0] {IDLE, RECV, PROC, ECHO, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, RECV, PROC, DONE} state_t;
`endif
   localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);
   state_t      state_q, state_d, exit_s;
   logic        type_q, type_d, err_q, err_d, flag_q, flag_d, rdy_q;
   logic [31:0] value_q, value_d, dout_q, dout_d;
   logic [3:0]  count_q, count_d, nib;
   logic [7:0]  byte_q, byte_d;
   logic        is_dig, is_hex, is_ws, is_term;
   assign is_dig  = byte_q >= 8'h30 && byte_q <= 8'h39;
   assign is_hex  = is_dig || (byte_q >= 8'h41 && byte_q <= 8'h46) || (byte_q >= 8'h61 && byte_q <= 8'h66);
   assign nib     = is_dig ? byte_q[3:0] : byte_q[3:0] + 4'd9;
   assign is_ws   = byte_q == 8'h20 || byte_q == 8'h0D || byte_q == 8'h0A;
   // a space only terminates a word once at least one digit has been seen
   assign is_term = is_ws && (byte_q != 8'h20 || count_q != 4'd0);
   assign ack_rx  = state_q == DONE;
   assign flag_rx = flag_q;
   assign dout_rx = dout_q;
   assign rdy_rx  = rdy_q;
`ifdef SDU_SCAN_ECHO_EN
   state_t post_q, post_d;
   assign vld_tx = state_q == ECHO;
   assign d_tx   = vld_tx ? byte_q : 8'h00;
   always_ff @(posedge clk) post_q <= rst ? IDLE : post_d;
`else
   logic unused_rdy_tx;
   assign vld_tx        = 1'b0;
   assign d_tx          = 8'h00;
   assign unused_rdy_tx = rdy_tx;
`endif
   always_comb begin
      state_d = state_q;
      exit_s  = RECV;
      type_d  = type_q;
      value_d = value_q;
      count_d = count_q;
      err_d   = err_q;
      byte_d  = byte_q;
      dout_d  = dout_q;
      flag_d  = flag_q;
`ifdef SDU_SCAN_ECHO_EN
      post_d  = post_q;
`endif
      case (state_q)
         IDLE: if (req_rx) begin
            type_d  = type_rx;
            value_d = '0;
            count_d = '0;
            err_d   = 1'b0;
            state_d = RECV;
         end
         RECV: if (vld_rx && rdy_rx) begin
            byte_d  = d_rx;
            state_d = PROC;
         end
         PROC: begin
            if (!type_q) begin
               if (!is_ws) begin
                  dout_d = {24'b0, byte_q};
                  flag_d = 1'b1;
                  exit_s = DONE;
               end
            end else if (is_hex) begin
               if (count_q < MAX_CNT) begin
                  value_d = {value_q[27:0], nib};
                  count_d = count_q + 4'd1;
               end else err_d = 1'b1;
            end else if (byte_q == 8'h08) begin
               if (count_q != 4'd0) begin
                  value_d = value_q >> 4;
                  count_d = count_q - 4'd1;
               end
            end else if (is_term) begin
               dout_d = value_q;
               flag_d = count_q != 4'd0 && !err_q;
               exit_s = DONE;
            end else if (!is_ws) err_d = 1'b1;
`ifdef SDU_SCAN_ECHO_EN
            post_d  = exit_s;
            state_d = ECHO;
`else
            state_d = exit_s;
`endif
         end
`ifdef SDU_SCAN_ECHO_EN
         ECHO: if (rdy_tx) state_d = post_q;
`endif
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         type_q  <= 1'b0;
         value_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         byte_q  <= '0;
         dout_q  <= '0;
         flag_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         value_q <= value_d;
         count_q <= count_d;
         err_q   <= err_d;
         byte_q  <= byte_d;
         dout_q  <= dout_d;
         flag_q  <= flag_d;
         rdy_q   <= state_d == RECV;
      end
   end
endmodule

// File: tb/tb_sdu_scan.sv
// tb_sdu_scan: scoreboard bench for sdu_scan with directed cases and a digit-list reference model.
// Echo checks are active when SDU_SCAN_ECHO_EN is defined.
module tb_sdu_scan;
   localparam int MAX_DIGITS = 8;
   logic        clk = 0, rst = 1, req_rx = 0, type_rx = 0, vld_rx = 0, rdy_tx = 0;
   logic [7:0]  d_rx = 0;
   logic        ack_rx, flag_rx, rdy_rx, vld_tx;
   logic [31:0] dout_rx;
   logic [7:0]  d_tx;
   int          checks = 0, errors = 0, acks = 0, cyc = 0, last_xfer = 0;
   logic        ack_prev = 0;
   logic [32:0] exp_q[$];
   logic [7:0]  echo_q[$];
   int          digs[$];
   bit          merr;
   string       hx = "0123456789abcdefABCDEF";

   sdu_scan #(.MAX_DIGITS(MAX_DIGITS)) dut (
      .clk(clk), .rst(rst), .req_rx(req_rx), .type_rx(type_rx), .ack_rx(ack_rx),
      .flag_rx(flag_rx), .dout_rx(dout_rx), .vld_rx(vld_rx), .d_rx(d_rx), .rdy_rx(rdy_rx),
      .vld_tx(vld_tx), .d_tx(d_tx), .rdy_tx(rdy_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1 rdy_tx = $urandom_range(0, 3) == 0;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   always @(negedge clk) begin
      if (rst) ack_prev = 0;
      else begin
         if (ack_rx) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack got flag=%b dout=%h want no ack", flag_rx, dout_rx);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               if ({flag_rx, dout_rx} !== e) begin
                  errors++;
                  $display("FAIL result got flag=%b dout=%h want flag=%b dout=%h", flag_rx, dout_rx, e[32], e[31:0]);
               end
            end
            checks++;
            if (ack_prev) begin
               errors++;
               $display("FAIL ack_width got ack high 2 cycles want 1");
            end
`ifndef SDU_SCAN_ECHO_EN
            checks++;
            if (cyc - last_xfer != 1) begin
               errors++;
               $display("FAIL latency got %0d want 2 cycles after last transfer", cyc - last_xfer + 1);
            end
`endif
            acks++;
         end
         ack_prev = ack_rx;
`ifdef SDU_SCAN_ECHO_EN
         if (vld_tx) begin
            checks++;
            if (rdy_rx) begin
               errors++;
               $display("FAIL rdy_during_echo got rdy_rx=1 want 0");
            end
            if (rdy_tx) begin
               checks++;
               if (echo_q.size() == 0 || d_tx !== echo_q[0]) begin
                  errors++;
                  $display("FAIL echo got %h want %h", d_tx, echo_q.size() ? echo_q[0] : 8'hxx);
               end
               if (echo_q.size()) void'(echo_q.pop_front());
            end
         end
`endif
      end
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      vld_rx = 1;
      d_rx = b;
      while (!rdy_rx && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!rdy_rx) begin
         checks++;
         errors++;
         $display("FAIL send_timeout byte=%h got no rdy_rx want rdy_rx=1", b);
         vld_rx = 0;
         return;
      end
      @(posedge clk);
      #1 vld_rx = 0;
      last_xfer = cyc;
      echo_q.push_back(b);
   endtask

   task automatic do_req(input logic t);
      @(negedge clk);
      req_rx = 1;
      type_rx = t;
      @(posedge clk);
      #1 req_rx = 0;
   endtask

   task automatic wait_ack();
      int a0, n;
      a0 = acks;
      n = 0;
      while (acks == a0 && n < 300) begin
         @(posedge clk);
         #1 n++;
      end
      if (acks == a0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout got no ack want ack");
      end
   endtask

   task automatic run_str(input logic t, input string s, input logic [32:0] e);
      do_req(t);
      exp_q.push_back(e);
      for (int i = 0; i < s.len(); i++) send(s[i]);
      wait_ack();
   endtask

   function automatic int hexval(input logic [7:0] b);
      if (b >= "0" && b <= "9") return int'(b) - 'h30;
      if (b >= "a" && b <= "f") return int'(b) - 'h61 + 10;
      if (b >= "A" && b <= "F") return int'(b) - 'h41 + 10;
      return -1;
   endfunction

   task automatic model_hex(input logic [7:0] b, output bit done, output logic [32:0] e);
      int v;
      logic [31:0] w;
      done = 0;
      e = '0;
      v = hexval(b);
      if (v >= 0) begin
         if (digs.size() < MAX_DIGITS) digs.push_back(v);
         else merr = 1;
      end else if (b == 8'h08) begin
         if (digs.size() > 0) void'(digs.pop_back());
      end else if (b == 8'h20 && digs.size() == 0) begin
      end else if (b == 8'h0D || b == 8'h0A || b == 8'h20) begin
         w = 0;
         foreach (digs[i]) w = (w << 4) | 32'(digs[i]);
         done = 1;
         e = {digs.size() > 0 && !merr, w};
      end else merr = 1;
   endtask

   initial begin
      logic [7:0]  b;
      logic [32:0] e;
      bit          done;
      int          n;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      checks++;
      if (ack_rx !== 0 || flag_rx !== 0 || dout_rx !== 0 || rdy_rx !== 0 || vld_tx !== 0 || d_tx !== 0) begin
         errors++;
         $display("FAIL reset_state got ack=%b flag=%b dout=%h rdy=%b vld_tx=%b d_tx=%h want all 0",
                  ack_rx, flag_rx, dout_rx, rdy_rx, vld_tx, d_tx);
      end
      run_str(0, " R", {1'b1, 32'h52});
      run_str(1, "1a2B\015", {1'b1, 32'h1a2b});
      run_str(1, "123456789\015", {1'b0, 32'h12345678});
      run_str(1, "\015", {1'b0, 32'h0});
      run_str(1, "12\0103\012", {1'b1, 32'h13});
      run_str(1, "4G5\015", {1'b0, 32'h45});
      run_str(0, "\012\015Z", {1'b1, 32'h5a});
      do_req(1);
      send("A");
      send("B");
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      checks++;
      if (ack_rx !== 0 || flag_rx !== 0 || dout_rx !== 0 || rdy_rx !== 0 || vld_tx !== 0) begin
         errors++;
         $display("FAIL mid_reset got ack=%b flag=%b dout=%h rdy=%b vld_tx=%b want all 0",
                  ack_rx, flag_rx, dout_rx, rdy_rx, vld_tx);
      end
      rst = 0;
      echo_q.delete();
      run_str(1, "7 ", {1'b1, 32'h7});
      do_req(0);
      @(negedge clk);
      req_rx = 1;
      type_rx = 1;
      @(posedge clk);
      #1 req_rx = 0;
      exp_q.push_back({1'b1, 32'h51});
      send("Q");
      wait_ack();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            do_req(0);
            done = 0;
            while (!done) begin
               if ($urandom_range(0, 2) == 0) begin
                  n = $urandom_range(0, 2);
                  b = n == 0 ? 8'h20 : n == 1 ? 8'h0D : 8'h0A;
               end else begin
                  b = 8'($urandom_range(33, 126));
                  done = 1;
                  exp_q.push_back({1'b1, 24'b0, b});
               end
               send(b);
            end
         end else begin
            do_req(1);
            digs.delete();
            merr = 0;
            done = 0;
            n = 0;
            while (!done) begin
               int r;
               r = $urandom_range(0, 23);
               if (n >= 24) b = 8'h0D;
               else if (r < 16) b = hx[$urandom_range(0, 21)];
               else if (r == 16) b = 8'h08;
               else if (r == 17) b = 8'h20;
               else if (r == 18) b = "G";
               else if (r == 19) b = "z";
               else if (r == 20) b = 8'h08;
               else if (r == 21) b = "x";
               else if (r == 22) b = 8'h0D;
               else b = 8'h0A;
               model_hex(b, done, e);
               if (done) exp_q.push_back(e);
               send(b);
               n++;
            end
         end
         wait_ack();
      end
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover got %0d pending results want 0", exp_q.size());
      end
`ifndef SDU_SCAN_ECHO_EN
      checks++;
      if (vld_tx !== 0 || d_tx !== 0) begin
         errors++;
         $display("FAIL echo_off got vld_tx=%b d_tx=%h want 0", vld_tx, d_tx);
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sdu_scan.md
Name: sdu_scan

Overview:
- Receive-side counterpart of the datapath print path in the serial debug unit.
- Accepts ASCII bytes from the UART receiver and parses one item per request: either a single command character or a hexadecimal word terminated by Enter.
- Returns the parsed value to the debug controller over a req/ack handshake.
- Optionally echoes accepted characters back to the UART transmitter.

Parameters:
- MAX_DIGITS, 8, maximum hex digits accepted in one word; range 1..8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_rx  input  1  scan request from debug controller
- type_rx  input  1  item type: 0 = command char, 1 = hex word; sampled with req_rx
- ack_rx  output  1  one-cycle pulse; dout_rx/flag_rx valid from this cycle
- flag_rx  output  1  1 = item valid, 0 = empty or malformed hex word
- dout_rx  output  32  parsed value; char in [7:0], upper bits zero
- vld_rx  input  1  UART receiver byte valid
- d_rx  input  8  UART receiver byte
- rdy_rx  output  1  scanner ready to take a byte
- vld_tx  output  1  echo byte valid (ECHO_EN only)
- d_tx  output  8  echo byte
- rdy_tx  input  1  UART transmitter ready

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high; it is the only reset in the block.
- Reset values: ack_rx=0, flag_rx=0, dout_rx=0, rdy_rx=0, vld_tx=0, d_tx=0, state IDLE, internal value/count/err all 0.
- A byte is transferred in any cycle with vld_rx&&rdy_rx. rdy_rx is registered and deasserts in the cycle after a transfer.
- States: IDLE, RECV, PROC, ECHO, DONE.
- IDLE:
  - rdy_rx=0.
  - req_rx=1: latch type_rx, clear value/count/err, go to RECV.
  - dout_rx/flag_rx hold their previous values until this new request is accepted.
- RECV: rdy_rx=1. On a transfer, latch the byte and go to PROC.
- PROC, type 0 (command char):
  - 0x20, 0x0D, 0x0A are ignored; return to RECV.
  - Any other byte: dout_rx={24'b0,byte}, flag_rx=1, go to DONE.
- PROC, type 1 (hex word):
  - Digits 0-9, a-f, A-F: value={value[27:0],nibble}.
    - If count<MAX_DIGITS, count++.
    - Otherwise set err and leave value unchanged.
  - 0x08 (backspace): if count>0, value=value>>4 and count--; otherwise no effect.
  - 0x20 with count==0 is ignored.
  - Terminators: 0x0D, 0x0A, or 0x20 with count>0.
    - dout_rx=value, flag_rx=(count>0)&&!err, go to DONE.
  - Any other byte sets err.
  - Non-terminating bytes return to RECV.
- ECHO_EN routing: the PROC exits above pass through ECHO before RECV/DONE.
- DONE: ack_rx=1 for exactly one cycle, then IDLE.
- Latency without echo:
  - Terminator transferred in cycle N: PROC in N+1, ack_rx high in N+2.
  - The earliest next request is accepted in N+3.
- req_rx is ignored outside IDLE. A held req_rx starts a new scan immediately after DONE.
- Simultaneous rst and vld_rx: rst wins; the byte is dropped.
- Reset mid-scan: return to IDLE with all outputs at reset values. A partial word is discarded.
- Arithmetic: value is 32 bits; shifts discard the MSBs. dout_rx holds the low 4*count bits.

Optional Feature:
- Macro: SDU_SCAN_ECHO_EN.
- Defined:
  - Every byte transferred in RECV enters ECHO: vld_tx=1, d_tx=byte until rdy_tx=1.
  - In the cycle after the echo handshake, go to RECV or DONE.
  - Echo applies to ignored and error bytes too.
  - For a terminator, ack_rx is asserted after the echo completes.
- Undefined: ECHO state absent; vld_tx and d_tx tied to 0; rdy_tx unused; latency as above.

Test Plan:
- Command: req type 0; bytes 0x20,'R' -> ack_rx one pulse, dout_rx=0x00000052, flag_rx=1.
- Hex word: req type 1; "1a2B" then 0x0D -> dout_rx=0x00001A2B, flag_rx=1, ack_rx 2 cycles after the 0x0D transfer.
- Boundary: type 1; nine digits "123456789" then 0x0D -> flag_rx=0, dout_rx=0x12345678. Empty word: 0x0D alone -> flag_rx=0, dout_rx=0.
- Editing/errors:
  - "12", 0x08, "3", 0x0A -> dout_rx=0x13, flag_rx=1.
  - "4G5" then 0x0D -> flag_rx=0.
- Reset/req:
  - rst after "AB" mid-scan -> outputs 0, state IDLE.
  - New req with "7" then 0x20 -> dout_rx=0x7, flag_rx=1.
  - req_rx pulsed during RECV -> ignored.
- With SDU_SCAN_ECHO_EN:
  - "5" then 0x0D, with rdy_tx held low 3 cycles per byte -> d_tx shows 0x35 then 0x0D.
  - rdy_rx stays low while vld_tx=1.
  - ack_rx follows the second echo handshake.
